// File: rtl/fp_add_align_if.sv
// fp_add_align_if: operand-pair and aligned-result handshake bundle for fp_add_align.
interface fp_add_align_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
   localparam int AW = MAN_W + 4;
   logic in_valid;
   logic in_ready;
   logic in_sub;
   logic [EXP_W+MAN_W:0] in_a;
   logic [EXP_W+MAN_W:0] in_b;
   logic out_valid;
   logic out_ready;
   logic [AW-1:0] out_man_l;
   logic [AW-1:0] out_man_s;
   logic [EXP_W-1:0] out_exp;
   logic out_sign;
   logic out_op;
   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input in_ready, out_valid, out_man_l, out_man_s, out_exp, out_sign, out_op
   );
   modport slave (
      input in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_man_l, out_man_s, out_exp, out_sign, out_op
   );
endinterface

// File: rtl/fp_add_align.sv
// fp_add_align: two-stage IEEE-754 operand swap and mantissa alignment ahead of an adder.
// Define FP_ALIGN_STICKY_EN to fold shifted-out bits into the LSB of out_man_s.
module fp_add_align #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input logic clk,
   input logic rst,
   fp_add_align_if.slave bus
);
   localparam int AW = MAN_W + 4;
   logic sign_a, sign_b, b_gt;
   logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b;
   logic [MAN_W-1:0] frac_a, frac_b;
   logic [AW-1:0] man_a, man_b;
   logic s1_valid, s1_sign, s1_op, s1_ld;
   logic [AW-1:0] s1_man_l, s1_man_s;
   logic [EXP_W-1:0] s1_exp, s1_d;
   logic s2_valid, s2_sign, s2_op, s2_ld;
   logic [AW-1:0] s2_man_l, s2_man_s;
   logic [EXP_W-1:0] s2_exp;
   logic big;
   logic [AW-1:0] shifted, aligned;
   assign {sign_a, exp_a, frac_a} = bus.in_a;
   assign {exp_b, frac_b} = bus.in_b[EXP_W+MAN_W-1:0];
   assign sign_b = bus.in_b[EXP_W+MAN_W] ^ bus.in_sub;
   assign eff_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
   assign eff_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
   assign man_a = {exp_a != '0, frac_a, 3'b000};
   assign man_b = {exp_b != '0, frac_b, 3'b000};
   assign b_gt = {exp_b, frac_b} > {exp_a, frac_a};
   assign s2_ld = !s2_valid || bus.out_ready;
   assign s1_ld = !s1_valid || s2_ld;
   assign bus.in_ready = s1_ld;
   // Distances of AW or more push every data bit past the LSB.
   assign big = 32'(s1_d) >= AW;
   assign shifted = big ? '0 : s1_man_s >> s1_d;
`ifdef FP_ALIGN_STICKY_EN
   logic [AW-1:0] mask;
   assign mask = big ? '1 : (AW'(1) << s1_d) - AW'(1);
   assign aligned = {shifted[AW-1:1], shifted[0] | (|(s1_man_s & mask))};
`else
   assign aligned = shifted;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_man_l <= '0;
         s1_man_s <= '0;
         s1_exp <= '0;
         s1_d <= '0;
         s1_sign <= 1'b0;
         s1_op <= 1'b0;
         s2_valid <= 1'b0;
         s2_man_l <= '0;
         s2_man_s <= '0;
         s2_exp <= '0;
         s2_sign <= 1'b0;
         s2_op <= 1'b0;
      end else begin
         if (s1_ld)
            s1_valid <= bus.in_valid;
         if (s1_ld && bus.in_valid) begin
            s1_man_l <= b_gt ? man_b : man_a;
            s1_man_s <= b_gt ? man_a : man_b;
            s1_exp <= b_gt ? eff_b : eff_a;
            s1_d <= b_gt ? eff_b - eff_a : eff_a - eff_b;
            s1_sign <= b_gt ? sign_b : sign_a;
            s1_op <= sign_a ^ sign_b;
         end
         if (s2_ld)
            s2_valid <= s1_valid;
         if (s2_ld && s1_valid) begin
            s2_man_l <= s1_man_l;
            s2_man_s <= aligned;
            s2_exp <= s1_exp;
            s2_sign <= s1_sign;
            s2_op <= s1_op;
         end
      end
   end
   assign bus.out_valid = s2_valid;
   assign bus.out_man_l = s2_man_l;
   assign bus.out_man_s = s2_man_s;
   assign bus.out_exp = s2_exp;
   assign bus.out_sign = s2_sign;
   assign bus.out_op = s2_op;
endmodule

// File: tb/tb_fp_add_align.sv
// tb_fp_add_align: directed and randomized checks of fp_add_align against an arithmetic model.
module tb_fp_add_align;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int AW = MAN_W + 4;
   localparam int W = 1 + EXP_W + MAN_W;
`ifdef FP_ALIGN_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif
   typedef struct packed {
      logic [AW-1:0] ml;
      logic [AW-1:0] ms;
      logic [EXP_W-1:0] e;
      logic s;
      logic op;
   } res_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_vec = 0;
   int n_err = 0;
   res_t q[$];
   bit stall = 1'b0;
   res_t snap;
   fp_add_align_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
   fp_add_align #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic res_t mk(longint ml, longint ms, int e, bit s, bit op);
      res_t r;
      r.ml = AW'(ml);
      r.ms = AW'(ms);
      r.e = EXP_W'(e);
      r.s = s;
      r.op = op;
      return r;
   endfunction
   // Magnitudes, exponents and the alignment shift done as plain integer arithmetic.
   function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic sub);
      longint unit, fa, fb, ma, mb, ms, span, sh;
      int ea, eb, xa, xb, d;
      bit sa, sb, swap, lost;
      unit = longint'(1) << MAN_W;
      sa = a[W-1];
      sb = b[W-1] ^ sub;
      ea = int'(a[W-2:MAN_W]);
      eb = int'(b[W-2:MAN_W]);
      fa = longint'(a[MAN_W-1:0]);
      fb = longint'(b[MAN_W-1:0]);
      swap = (longint'(eb) * unit + fb) > (longint'(ea) * unit + fa);
      xa = (ea == 0) ? 1 : ea;
      xb = (eb == 0) ? 1 : eb;
      ma = (((ea != 0) ? unit : 0) + fa) * 8;
      mb = (((eb != 0) ? unit : 0) + fb) * 8;
      d = swap ? xb - xa : xa - xb;
      ms = swap ? ma : mb;
      if (d >= AW) begin
         sh = 0;
         lost = ms != 0;
      end else begin
         span = longint'(1) << d;
         sh = ms / span;
         lost = (ms % span) != 0;
      end
      if (STICKY && lost)
         sh = sh | 1;
      return mk(swap ? mb : ma, sh, swap ? xb : xa, swap ? sb : sa, sa ^ sb);
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // One clock: sample just after the falling edge, then ride through the next rising edge.
   task automatic tick(input res_t e, output bit acc);
      res_t r;
      #1;
      acc = 1'b0;
      if (stall && !rst) begin
         chk("hold_valid", 64'(bus.out_valid), 64'd1);
         chk("hold_data", 64'({bus.out_man_l, bus.out_man_s, bus.out_exp, bus.out_sign, bus.out_op}), 64'(snap));
      end
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0)
            chk("spurious_out", 64'(bus.out_valid), 64'd0);
         else begin
            r = q.pop_front();
            chk("man_l", 64'(bus.out_man_l), 64'(r.ml));
            chk("man_s", 64'(bus.out_man_s), 64'(r.ms));
            chk("exp", 64'(bus.out_exp), 64'(r.e));
            chk("sign", 64'(bus.out_sign), 64'(r.s));
            chk("op", 64'(bus.out_op), 64'(r.op));
         end
      end
      if (!rst && bus.in_valid && bus.in_ready) begin
         q.push_back(e);
         acc = 1'b1;
      end
      if (rst)
         q.delete();
      stall = !rst && bus.out_valid && !bus.out_ready;
      snap = {bus.out_man_l, bus.out_man_s, bus.out_exp, bus.out_sign, bus.out_op};
      @(negedge clk);
   endtask
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input res_t e);
      bit acc = 1'b0;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_sub = sub;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20 && !acc; i++)
         tick(e, acc);
      if (!acc)
         chk("send_timeout", 64'(acc), 64'd1);
      bus.in_valid = 1'b0;
   endtask
   task automatic drain();
      bit acc;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++)
         tick(mk(0, 0, 0, 0, 0), acc);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask
   initial begin
      res_t e;
      bit acc, pend;
      logic [W-1:0] a, b;
      logic sub;
      int k;
      bus.in_valid = 1'b1;
      bus.in_a = 32'h3F800000;
      bus.in_b = 32'h40000000;
      bus.in_sub = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      tick(mk(0, 0, 0, 0, 0), acc);
      tick(mk(0, 0, 0, 0, 0), acc);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_data", 64'({bus.out_man_l, bus.out_man_s, bus.out_exp, bus.out_sign, bus.out_op}), 64'd0);
      // 1.0 + 2.0 with an explicit two-cycle latency check.
      bus.in_valid = 1'b1;
      tick(mk(27'h4000000, 27'h2000000, 8'h80, 0, 0), acc);
      chk("accept_first", 64'(acc), 64'd1);
      bus.in_valid = 1'b0;
      chk("lat_cycle1", 64'(bus.out_valid), 64'd0);
      tick(mk(0, 0, 0, 0, 0), acc);
      chk("lat_cycle2", 64'(bus.out_valid), 64'd1);
      tick(mk(0, 0, 0, 0, 0), acc);
      send(32'h3F800000, 32'h3F800000, 1'b1, mk(27'h4000000, 27'h4000000, 8'h7F, 0, 1));
      send(32'h4B800000, 32'h3F800001, 1'b0, mk(27'h4000000, STICKY ? 27'h5 : 27'h4, 8'h97, 0, 0));
      send(32'h3F800000, 32'h4F000000, 1'b0, mk(27'h4000000, STICKY ? 27'h1 : 27'h0, 8'h9E, 0, 0));
      drain();
      // Backpressure: two pairs fill the pipe, the third waits.
      bus.out_ready = 1'b0;
      send(32'h40400000, 32'hC0000000, 1'b0, model(32'h40400000, 32'hC0000000, 1'b0));
      send(32'h41200000, 32'h3DCCCCCD, 1'b1, model(32'h41200000, 32'h3DCCCCCD, 1'b1));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_a = 32'h00400000;
      bus.in_b = 32'h80000001;
      bus.in_sub = 1'b0;
      bus.in_valid = 1'b1;
      e = model(32'h00400000, 32'h80000001, 1'b0);
      tick(e, acc);
      chk("bp_stall1", 64'(acc), 64'd0);
      tick(e, acc);
      chk("bp_stall2", 64'(acc), 64'd0);
      bus.out_ready = 1'b1;
      send(32'h00400000, 32'h80000001, 1'b0, e);
      drain();
      // Reset with both stages full discards everything, including the pair offered during reset.
      bus.out_ready = 1'b0;
      send(32'h3F800000, 32'h40000000, 1'b0, mk(0, 0, 0, 0, 0));
      send(32'h3F800000, 32'h40000000, 1'b1, mk(0, 0, 0, 0, 0));
      chk("full_out_valid", 64'(bus.out_valid), 64'd1);
      rst = 1'b1;
      bus.in_valid = 1'b1;
      tick(mk(0, 0, 0, 0, 0), acc);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(mk(0, 0, 0, 0, 0), acc);
         chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
      end
      // Randomized traffic with random backpressure; held operands stay put until accepted.
      pend = 1'b0;
      a = '0;
      b = '0;
      sub = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 4);
            if (k == 1)
               b[W-2:MAN_W] = a[W-2:MAN_W] + EXP_W'($urandom_range(0, 6)) - EXP_W'(3);
            else if (k == 2)
               b = {1'($urandom_range(0, 1)), a[W-2:0]};
            else if (k == 3)
               a[W-2:MAN_W] = '0;
            else if (k == 4)
               b[W-2:MAN_W] = a[W-2:MAN_W] - EXP_W'($urandom_range(20, 40));
            bus.in_a = a;
            bus.in_b = b;
            bus.in_sub = sub;
            bus.in_valid = $urandom_range(0, 3) != 0;
         end
         bus.out_ready = $urandom_range(0, 3) != 0;
         tick(model(a, b, sub), acc);
         pend = bus.in_valid && !acc;
      end
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fp_add_align.md
FP_ADD_ALIGN -- requirements
Module: fp_add_align

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; internal aligned width AW = MAN_W+4 (hidden bit, fraction, guard, round, sticky).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: in_valid  in  1  operand pair present.
REQ-007 Port: in_ready  out  1  block accepts operand pair.
REQ-008 Port: in_a  in  1+EXP_W+MAN_W  IEEE-754 operand A.
REQ-009 Port: in_b  in  1+EXP_W+MAN_W  IEEE-754 operand B.
REQ-010 Port: in_sub  in  1  requested operation, 1 = A-B.
REQ-011 Port: out_valid  out  1  aligned result present.
REQ-012 Port: out_ready  in  1  downstream N-bit adder stage accepts.
REQ-013 Port: out_man_l  out  AW  larger-magnitude mantissa, GRS bits zero.
REQ-014 Port: out_man_s  out  AW  smaller mantissa, right-aligned to out_exp.
REQ-015 Port: out_exp  out  EXP_W  effective exponent of larger operand.
REQ-016 Port: out_sign  out  1  effective sign of larger operand.
REQ-017 Port: out_op  out  1  effective subtract (drives adder c_in/invert).

Function
REQ-018 SHALL decode each operand: exponent 0 -> hidden bit 0, effective exponent 1; otherwise hidden bit 1, exponent as stored.
REQ-019 SHALL apply effective sign of B = sign_b XOR in_sub; out_op = sign_a XOR effective sign_b.
REQ-020 Stage 1 SHALL compare {exp,frac} magnitudes, swap so larger is "l" (tie: A is l), register mantissas, exponent, sign, op and d = exp_l - exp_s.
REQ-021 Stage 2 SHALL right-shift {hidden,frac,000} of s by d; d >= AW yields all shifted data bits zero.
REQ-022 Latency SHALL be exactly 2 cycles from accepted input to out_valid with no backpressure; throughput one pair per cycle.
REQ-023 Stage advance rule: s2 loads when !s2_valid or out_ready; s1 loads when !s1_valid or s2 loads; in_ready = !s1_valid or s2 loads.
REQ-024 Transfer occurs only when valid and ready both high on a rising edge.
REQ-025 While out_valid=1 and out_ready=0, all out_* SHALL hold stable; no pair dropped, duplicated or reordered.
REQ-026 in_valid with in_ready=0 SHALL be ignored; source holds data.
REQ-027 NaN/Inf SHALL not be special-cased; fields pass through arithmetically.

Reset
REQ-028 rst=1 at a rising edge SHALL clear s1_valid, s2_valid; out_valid=0, in_ready=1 next cycle.
REQ-029 After reset out_man_l, out_man_s, out_exp, out_sign, out_op SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight pairs; input offered during reset cycle not accepted.

Configuration
REQ-031 Macro FP_ALIGN_STICKY_EN defined: out_man_s bit 0 = OR of shifted bit 0 and all bits shifted out (sticky).
REQ-032 Macro FP_ALIGN_STICKY_EN undefined: out_man_s = plain truncated shift; shifted-out bits discarded.

Verification
REQ-033 A=0x3F800000, B=0x40000000, sub=0, out_ready=1 -> 2 cycles later man_l=0x4000000, man_s=0x2000000, exp=0x80, sign=0, op=0.
REQ-034 A=0x3F800000, B=0x3F800000, sub=1 -> man_l=man_s=0x4000000, exp=0x7F, sign=0, op=1.
REQ-035 A=0x4B800000, B=0x3F800001 (d=24) -> man_s=0x5 with STICKY_EN, 0x4 without; exp=0x97.
REQ-036 A=0x3F800000, B=0x4F000000 (d=31, swap) -> man_l=0x4000000, exp=0x9E, man_s=0x1 with STICKY_EN, 0x0 without.
REQ-037 Three back-to-back pairs, out_ready=0 for 4 cycles -> in_ready falls after two accepted, outputs frozen, then all three delivered in order.
REQ-038 rst pulsed with both stages valid -> out_valid=0 next cycle, no stale result appears afterwards.
